// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain driver: serialises bitstream bytes MSB-first onto ccff_head and
// provides a non-destructive recirculating readback that counts ones seen on ccff_tail.
`timescale 1ns / 1ps

module ccff_bitstream_loader #(
    parameter int unsigned CHAIN_LEN = 12,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             prog_clk,
    input  logic             pReset,
    input  logic             cfg_start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ccff_head,
    input  logic             ccff_tail,
    output logic             shift_en,
    output logic             busy,
    output logic             load_done,
    input  logic             readback_start,
    output logic [CNT_W-1:0] rb_ones,
    output logic             rb_done,
    output logic             err_overflow
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone,
        StRb
    } state_e;

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [7:0]       sr_q, sr_d;
    logic [3:0]       bits_left_q, bits_left_d;
    logic [CNT_W-1:0] chain_cnt_q, chain_cnt_d;
    logic [CNT_W-1:0] rb_ones_q, rb_ones_d;
    logic             err_overflow_q, err_overflow_d;
    logic             rb_done_q, rb_done_d;

    logic             shift_cond;
    logic             ready_cond;
    logic             head_raw;
    logic             at_last;
    logic             accept;

    assign at_last = (chain_cnt_q == LastIdx);

    // Raw shift/ready conditions; reset gating is applied on the output assigns below.
    always_comb begin
        shift_cond = 1'b0;
        ready_cond = 1'b0;
        head_raw   = 1'b0;
        unique case (state_q)
            StLoad: begin
                shift_cond = (bits_left_q != 4'd0);
                // The final chain bit closes the load, so no new byte may land with it.
                ready_cond = (bits_left_q <= 4'd1) && !(shift_cond && at_last);
                head_raw   = sr_q[7];
            end
            StDone: begin
                ready_cond = 1'b1;
            end
            StRb: begin
                shift_cond = 1'b1;
                head_raw   = ccff_tail;
            end
            default: begin
            end
        endcase
    end

    assign shift_en  = pReset & shift_cond;
    assign in_ready  = pReset & ready_cond;
    assign ccff_head = shift_en & head_raw;
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d        = state_q;
        sr_d           = sr_q;
        bits_left_d    = bits_left_q;
        chain_cnt_d    = chain_cnt_q;
        rb_ones_d      = rb_ones_q;
        err_overflow_d = err_overflow_q;
        rb_done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    state_d        = StLoad;
                    chain_cnt_d    = '0;
                    bits_left_d    = 4'd0;
                    err_overflow_d = 1'b0;
                end
            end

            StLoad: begin
                if (shift_en) begin
                    if (at_last) begin
                        // Leftover bits of the current byte are dropped.
                        state_d     = StDone;
                        sr_d        = 8'h00;
                        bits_left_d = 4'd0;
                    end else begin
                        sr_d        = {sr_q[6:0], 1'b0};
                        bits_left_d = bits_left_q - 4'd1;
                        chain_cnt_d = chain_cnt_q + CntOne;
                    end
                end
                // A new byte overrides the final shift of the previous one.
                if (accept) begin
                    sr_d        = in_data;
                    bits_left_d = 4'd8;
                end
            end

            StDone: begin
                if (accept) begin
                    err_overflow_d = 1'b1;
                end
                if (cfg_start) begin
                    state_d        = StLoad;
                    chain_cnt_d    = '0;
                    bits_left_d    = 4'd0;
                    err_overflow_d = 1'b0;
                end else if (readback_start) begin
                    state_d     = StRb;
                    chain_cnt_d = '0;
                    rb_ones_d   = '0;
                end
            end

            StRb: begin
                rb_ones_d = rb_ones_q + {{(CNT_W - 1){1'b0}}, ccff_tail};
                if (at_last) begin
                    state_d   = StDone;
                    rb_done_d = 1'b1;
                end else begin
                    chain_cnt_d = chain_cnt_q + CntOne;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            state_q        <= StIdle;
            sr_q           <= 8'h00;
            bits_left_q    <= 4'd0;
            chain_cnt_q    <= '0;
            rb_ones_q      <= '0;
            err_overflow_q <= 1'b0;
            rb_done_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sr_q           <= sr_d;
            bits_left_q    <= bits_left_d;
            chain_cnt_q    <= chain_cnt_d;
            rb_ones_q      <= rb_ones_d;
            err_overflow_q <= err_overflow_d;
            rb_done_q      <= rb_done_d;
        end
    end

    assign busy         = (state_q == StLoad) || (state_q == StRb);
    assign load_done    = (state_q == StDone);
    assign rb_ones      = rb_ones_q;
    assign rb_done      = rb_done_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 12-flop chain model, a driver and a scoreboard monitor
// that checks every completed load and readback against an expected-event queue.
`timescale 1ns / 1ps

module tb_ccff_bitstream_loader;

    localparam int L = 12;
    localparam int W = 4;

    logic         prog_clk = 1'b0;
    logic         pReset = 1'b0;
    logic         cfg_start = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         ccff_head;
    logic         ccff_tail;
    logic         shift_en;
    logic         busy;
    logic         load_done;
    logic         readback_start = 1'b0;
    logic [W-1:0] rb_ones;
    logic         rb_done;
    logic         err_overflow;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(
        .CHAIN_LEN(L),
        .CNT_W    (W)
    ) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .cfg_start     (cfg_start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .shift_en      (shift_en),
        .busy          (busy),
        .load_done     (load_done),
        .readback_start(readback_start),
        .rb_ones       (rb_ones),
        .rb_done       (rb_done),
        .err_overflow  (err_overflow)
    );

    // Downstream configuration chain: bit L-1 is the tail flop.
    logic [L-1:0] chain = '0;
    always @(posedge prog_clk) begin
        if (shift_en) chain <= {chain[L-2:0], ccff_head};
    end
    assign ccff_tail = chain[L-1];

    typedef struct {
        bit           is_rb;
        logic [L-1:0] chain;
        int           ones;
        int           shifts;
        int           span;
        bit           err;
    } exp_t;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    logic [L-1:0] exp_chain = '0;
    bit           model_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: condition not reached within bound (t=%0t)", name, $time);
    endtask

    // The chain holds the first L bits of the byte stream, first-shifted bit at the tail.
    function automatic logic [L-1:0] expect_chain(input logic [7:0] b0, input logic [7:0] b1);
        logic [15:0] s;
        s = {b0, b1};
        return s[15-:L];
    endfunction

    // Monitor: on every rising edge of load_done, pop one expected event and compare.
    initial begin : monitor
        int   cyc;
        int   shifts;
        int   first_c;
        int   last_c;
        bit   ld_prev;
        exp_t e;
        cyc = 0; shifts = 0; first_c = 0; last_c = 0; ld_prev = 1'b0;
        forever begin
            @(negedge prog_clk);
            cyc++;
            if (pReset !== 1'b1) begin
                shifts = 0;
            end else if (shift_en === 1'b1) begin
                if (shifts == 0) first_c = cyc;
                last_c = cyc;
                shifts++;
            end
            if (load_done === 1'b1 && !ld_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: load_done rose with no expected event");
                end else begin
                    e = exp_q.pop_front();
                    check(e.is_rb ? "rb_done_flag" : "ld_rb_done_flag", 32'(rb_done),
                          32'(e.is_rb));
                    check(e.is_rb ? "rb_chain" : "ld_chain", 32'(chain), 32'(e.chain));
                    check(e.is_rb ? "rb_shifts" : "ld_shifts", shifts, e.shifts);
                    check(e.is_rb ? "rb_span" : "ld_span", last_c - first_c + 1, e.span);
                    check(e.is_rb ? "rb_latency" : "ld_latency", cyc - last_c, 1);
                    check(e.is_rb ? "rb_err" : "ld_err", 32'(err_overflow), 32'(e.err));
                    if (e.is_rb) check("rb_ones", 32'(rb_ones), e.ones);
                end
                shifts = 0;
            end
            ld_prev = (load_done === 1'b1);
        end
    end

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    // gap = number of ready cycles the byte is withheld before being offered.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int seen;
        int t;
        seen = 0;
        t = 0;
        in_valid = 1'b0;
        while (seen < gap && t < 100) begin
            if (in_ready) seen++;
            step();
            t++;
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            step();
            t++;
        end
        if (!in_ready) begin
            fail_now("send_timeout");
            in_valid = 1'b0;
            return;
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_load_done();
        int t;
        t = 0;
        while (load_done !== 1'b1 && t < 200) begin
            step();
            t++;
        end
        if (load_done !== 1'b1) fail_now("load_done_timeout");
    endtask

    task automatic do_load(input logic [7:0] b0, input logic [7:0] b1, input int g0,
                           input int g1, input bit poke_rb, input bit both);
        exp_t e;
        cfg_start      = 1'b1;
        readback_start = both;
        step();
        cfg_start      = 1'b0;
        readback_start = 1'b0;
        check("load_busy", 32'(busy), 1);
        check("load_err_clr", 32'(err_overflow), 0);
        if (both) begin
            check("both_no_rb_shift", 32'(shift_en), 0);
            check("both_load_ready", 32'(in_ready), 1);
        end
        model_err = 1'b0;
        exp_chain = expect_chain(b0, b1);
        e.is_rb  = 1'b0;
        e.chain  = exp_chain;
        e.ones   = 0;
        e.shifts = L;
        e.span   = L + g1;
        e.err    = 1'b0;
        exp_q.push_back(e);
        send_byte(b0, g0);
        if (poke_rb) begin
            readback_start = 1'b1;
            step();
            readback_start = 1'b0;
        end
        send_byte(b1, g1);
        wait_load_done();
    endtask

    task automatic do_readback(input bit poke_cfg);
        exp_t e;
        readback_start = 1'b1;
        step();
        readback_start = 1'b0;
        check("rb_busy", 32'(busy), 1);
        check("rb_ones_clr", 32'(rb_ones), 0);
        e.is_rb  = 1'b1;
        e.chain  = exp_chain;
        e.ones   = $countones(exp_chain);
        e.shifts = L;
        e.span   = L;
        e.err    = model_err;
        exp_q.push_back(e);
        if (poke_cfg) begin
            repeat (3) step();
            cfg_start = 1'b1;
            step();
            cfg_start = 1'b0;
            check("rb_cfg_ignored", 32'(shift_en), 1);
        end
        wait_load_done();
        step();
        check("rb_done_pulse", 32'(rb_done), 0);
        check("rb_ones_hold", 32'(rb_ones), $countones(exp_chain));
    endtask

    task automatic do_overflow(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        #1;
        check("ovf_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        model_err = 1'b1;
        check("ovf_set", 32'(err_overflow), 1);
        check("ovf_still_done", 32'(load_done), 1);
        repeat (2) step();
        check("ovf_sticky", 32'(err_overflow), 1);
    endtask

    task automatic do_reset_mid_load();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        send_byte(8'hC3, 0);
        repeat (5) step();
        check("rst_pre_shift", 32'(shift_en), 1);
        pReset = 1'b0;
        #1;
        check("rst_shift_en", 32'(shift_en), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        step();
        check("rst_busy", 32'(busy), 0);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_rb_ones", 32'(rb_ones), 0);
        check("rst_head", 32'(ccff_head), 0);
        check("rst_err", 32'(err_overflow), 0);
        pReset = 1'b1;
        step();
        check("rst_idle", 32'(busy), 0);
        model_err = 1'b0;
    endtask

    initial begin : stimulus
        logic [7:0] r0;
        logic [7:0] r1;
        int         g0;
        int         g1;
        int         t;

        repeat (3) step();
        check("reset_busy", 32'(busy), 0);
        check("reset_load_done", 32'(load_done), 0);
        check("reset_rb_done", 32'(rb_done), 0);
        check("reset_rb_ones", 32'(rb_ones), 0);
        check("reset_err", 32'(err_overflow), 0);
        check("reset_head", 32'(ccff_head), 0);
        check("reset_shift_en", 32'(shift_en), 0);
        check("reset_in_ready", 32'(in_ready), 0);

        pReset = 1'b1;
        readback_start = 1'b1;
        step();
        readback_start = 1'b0;
        check("idle_rb_ignored", 32'(busy), 0);
        check("idle_ready", 32'(in_ready), 0);

        do_load(8'hA5, 8'h3C, 0, 0, 1'b0, 1'b0);
        do_readback(1'b0);
        do_overflow(8'hFF);
        do_load(8'hA5, 8'h3C, 0, 3, 1'b0, 1'b0);
        do_readback(1'b1);
        do_load(8'h5A, 8'hF0, 1, 0, 1'b1, 1'b1);
        do_readback(1'b0);

        do_reset_mid_load();
        do_load(8'h81, 8'h7E, 2, 2, 1'b0, 1'b0);
        do_readback(1'b0);

        for (int i = 0; i < 10; i++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            g0 = int'($urandom_range(0, 3));
            g1 = int'($urandom_range(0, 3));
            do_load(r0, r1, g0, g1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) do_overflow(8'($urandom));
            do_readback(1'($urandom_range(0, 1)));
        end

        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            step();
            t++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
